// File: rtl/usi_pkg.sv
// Shared definitions for the USI SPI engine: FSM states, mode encodings and
// bit positions of the fields in the parameters register.
package usi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } usi_state_e;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_SPI = 2'b01;

  localparam int unsigned NBITS_LSB     = 0;
  localparam int unsigned NBITS_MSB     = 4;
  localparam int unsigned MSB_FIRST_BIT = 5;
  localparam int unsigned CPOL_BIT      = 6;

  // Position in the data word of the cnt-th bit on the wire.
  function automatic logic [4:0] bit_index(input logic       msb_first,
                                           input logic [4:0] nm1,
                                           input logic [4:0] cnt);
    return msb_first ? (nm1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/usi_clk_gen.sv
// SCLK half-period timer: counts 0..div-1 while enabled and flags the
// terminal count; held at zero while disabled.
module usi_clk_gen (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        enable,
  input  logic [31:0] div,
  output logic        tick
);

  logic [31:0] r_cnt;

  assign tick = enable && (r_cnt == div - 32'd1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (!enable || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/usi_spi_engine.sv
// SPI master shift engine: one transfer of 1..32 bits per tx_start, with
// selectable bit order and clock polarity; all outputs are registered.
module usi_spi_engine
  import usi_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        mode_sel,
  input  logic [31:0]       clkdiv,
  input  logic [31:0]       parameters,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ctrl_unit_error
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  usi_state_e r_state, w_state_nxt;

  logic [31:0]       r_div;
  logic [4:0]        r_nm1, r_bit_cnt;
  logic              r_msb_first, r_cpol;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic              r_sclk, r_mosi, r_ss_n, r_busy, r_done, r_err;

  logic              w_sclk_d, w_mosi_d, w_ss_n_d, w_busy_d, w_done_d;
  logic [DATA_W-1:0] w_rx_data_d;
  logic              w_tick, w_active, w_mode_ok, w_abort, w_start_ok, w_err;
  logic              w_shift_tick, w_lead, w_trail, w_finish;
  logic [IdxW-1:0]   w_start_idx, w_idx_cur, w_idx_nxt;
  logic              w_unused_params;

  assign w_unused_params = ^parameters[31:7];

  assign w_mode_ok  = (mode_sel == MODE_SPI);
  assign w_active   = (r_state == StLoad) || (r_state == StShift);
  assign w_abort    = w_active && !w_mode_ok;
  assign w_start_ok = (r_state == StIdle) && tx_start && w_mode_ok && (clkdiv != 32'd0);
  // Abort and a rejected start share one pulse when they coincide.
  assign w_err      = (tx_start && !w_start_ok) || w_abort;

  // Leading edge moves SCLK away from its idle level, trailing edge returns it.
  assign w_shift_tick = (r_state == StShift) && w_tick && !w_abort;
  assign w_lead       = w_shift_tick && (r_sclk == r_cpol);
  assign w_trail      = w_shift_tick && (r_sclk != r_cpol);
  assign w_finish     = w_trail && (r_bit_cnt == r_nm1);

  assign w_start_idx = IdxW'(bit_index(parameters[MSB_FIRST_BIT],
                                       parameters[NBITS_MSB:NBITS_LSB], 5'd0));
  assign w_idx_cur   = IdxW'(bit_index(r_msb_first, r_nm1, r_bit_cnt));
  assign w_idx_nxt   = IdxW'(bit_index(r_msb_first, r_nm1, r_bit_cnt + 5'd1));

  usi_clk_gen u_clk_gen (
    .CLK    (CLK),
    .nRST   (nRST),
    .enable (w_active),
    .div    (r_div),
    .tick   (w_tick)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_nxt = StLoad;
      StLoad:  if (w_abort) w_state_nxt = StIdle;
               else if (w_tick) w_state_nxt = StShift;
      StShift: if (w_abort) w_state_nxt = StIdle;
               else if (w_finish) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_sclk_d    = r_sclk;
    w_mosi_d    = r_mosi;
    w_ss_n_d    = r_ss_n;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_rx_data_d = r_rx_data;
    unique case (r_state)
      StIdle: begin
        if (w_start_ok) begin
          w_sclk_d = parameters[CPOL_BIT];
          w_mosi_d = tx_data[w_start_idx];
          w_ss_n_d = 1'b0;
          w_busy_d = 1'b1;
        end
      end
      StLoad, StShift: begin
        if (w_abort) begin
          w_sclk_d = r_cpol;
          w_ss_n_d = 1'b1;
          w_busy_d = 1'b0;
        end else if (w_shift_tick) begin
          w_sclk_d = ~r_sclk;
          if (w_trail) w_mosi_d = r_tx[w_idx_nxt];
          if (w_finish) begin
            w_done_d    = 1'b1;
            w_ss_n_d    = 1'b1;
            w_rx_data_d = r_rx;
          end
        end
      end
      StDone:  w_busy_d = 1'b0;
      default: w_busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_div       <= '0;
      r_nm1       <= '0;
      r_bit_cnt   <= '0;
      r_msb_first <= 1'b0;
      r_cpol      <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rx_data   <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_ss_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sclk    <= w_sclk_d;
      r_mosi    <= w_mosi_d;
      r_ss_n    <= w_ss_n_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_rx_data <= w_rx_data_d;
      r_err     <= w_err;
      if (w_start_ok) begin
        r_div       <= clkdiv;
        r_nm1       <= parameters[NBITS_MSB:NBITS_LSB];
        r_msb_first <= parameters[MSB_FIRST_BIT];
        r_cpol      <= parameters[CPOL_BIT];
        r_tx        <= tx_data;
        r_rx        <= '0;
        r_bit_cnt   <= '0;
      end
      if (w_lead) r_rx[w_idx_cur] <= miso;
      if (w_trail) r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  assign sclk            = r_sclk;
  assign mosi            = r_mosi;
  assign ss_n            = r_ss_n;
  assign busy            = r_busy;
  assign done            = r_done;
  assign rx_data         = r_rx_data;
  assign ctrl_unit_error = r_err;

endmodule

// File: tb/tb_usi_spi_engine.sv
// Loopback bench for usi_spi_engine: table of directed transfers plus
// hand-written error, abort and reset sequences.
module tb_usi_spi_engine;
  import usi_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  mode_sel;
  logic [31:0] clkdiv, parameters, tx_data;
  logic        tx_start;
  logic        miso;
  logic        sclk, mosi, ss_n, busy, done, ctrl_unit_error;
  logic [31:0] rx_data;

  usi_spi_engine #(.DATA_W(32)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .mode_sel        (mode_sel),
    .clkdiv          (clkdiv),
    .parameters      (parameters),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .miso            (miso),
    .sclk            (sclk),
    .mosi            (mosi),
    .ss_n            (ss_n),
    .busy            (busy),
    .done            (done),
    .rx_data         (rx_data),
    .ctrl_unit_error (ctrl_unit_error)
  );

  always #5 CLK = ~CLK;
  assign miso = mosi;

  int checks = 0;
  int failures = 0;

  // Observations of the most recent run
  int          done_cyc, pulses, errs;
  logic [31:0] cap;
  logic        s_ss, s_busy, s_sclk, s_mosi, s_err;

  typedef struct {
    logic [31:0] div;
    logic [31:0] prm;
    logic [31:0] data;
    int          exp_done;
    logic [31:0] exp_rx;
    int          exp_pulses;
    logic        exp_first;
    logic        exp_cpol;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Cycle 0 carries the tx_start pulse; cycle c is observed at its falling edge.
  task automatic run(input logic [1:0] m, input logic [31:0] div, input logic [31:0] prm,
                     input logic [31:0] data, input int ncyc, input int inj_start,
                     input int inj_abort, input int snap);
    logic [4:0] nm1;
    logic       msbf, cp, prev;
    int         k;
    logic [4:0] idx5;
    nm1  = prm[4:0];
    msbf = prm[5];
    cp   = prm[6];
    k    = 0;
    @(posedge CLK); #1;
    mode_sel   = m;
    clkdiv     = div;
    parameters = prm;
    tx_data    = data;
    tx_start   = 1'b1;
    done_cyc   = -1;
    pulses     = 0;
    errs       = 0;
    cap        = '0;
    @(negedge CLK);
    prev = sclk;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge CLK); #1;
      tx_start = (c == inj_start);
      if (c == inj_abort) mode_sel = MODE_OFF;
      @(negedge CLK);
      if (done && done_cyc < 0) done_cyc = c;
      if (ctrl_unit_error) errs++;
      if (sclk !== prev && sclk === !cp) begin
        if (k < 32) begin
          idx5 = msbf ? (nm1 - 5'(k)) : 5'(k);
          cap[idx5] = mosi;
        end
        k++;
        pulses++;
      end
      prev = sclk;
      if (c == snap) begin
        s_ss   = ss_n;
        s_busy = busy;
        s_sclk = sclk;
        s_mosi = mosi;
        s_err  = ctrl_unit_error;
      end
    end
    tx_start = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    nRST       = 1'b0;
    mode_sel   = MODE_OFF;
    clkdiv     = '0;
    parameters = '0;
    tx_data    = '0;
    tx_start   = 1'b0;
    #12;
    chk1("rst_sclk", sclk, 1'b0);
    chk1("rst_mosi", mosi, 1'b0);
    chk1("rst_ss_n", ss_n, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", ctrl_unit_error, 1'b0);
    chk("rst_rx", rx_data, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    vecs[0] = '{32'd2, 32'h27, 32'h000000A5, 35,  32'h000000A5, 8,  1'b1, 1'b0};
    vecs[1] = '{32'd1, 32'h5F, 32'hDEADBEEF, 66,  32'hDEADBEEF, 32, 1'b1, 1'b1};
    vecs[2] = '{32'd3, 32'h23, 32'hFFFFFFF6, 28,  32'h00000006, 4,  1'b0, 1'b0};
    vecs[3] = '{32'd1, 32'h00, 32'h00000001, 4,   32'h00000001, 1,  1'b1, 1'b0};
    vecs[4] = '{32'd2, 32'h44, 32'hFFFFFF13, 23,  32'h00000013, 5,  1'b1, 1'b1};
    vecs[5] = '{32'd4, 32'h6F, 32'h0000C3A1, 133, 32'h0000C3A1, 16, 1'b1, 1'b1};

    for (int i = 0; i < 6; i++) begin
      run(MODE_SPI, vecs[i].div, vecs[i].prm, vecs[i].data, vecs[i].exp_done + 2, -1, -1, 1);
      chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
      chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      chk($sformatf("v%0d_mosi_word", i), cap, vecs[i].exp_rx);
      chk($sformatf("v%0d_sclk_pulses", i), pulses, vecs[i].exp_pulses);
      chk($sformatf("v%0d_err_pulses", i), errs, 0);
      chk1($sformatf("v%0d_load_ss_n", i), s_ss, 1'b0);
      chk1($sformatf("v%0d_load_busy", i), s_busy, 1'b1);
      chk1($sformatf("v%0d_load_mosi", i), s_mosi, vecs[i].exp_first);
      chk1($sformatf("v%0d_load_sclk", i), s_sclk, vecs[i].exp_cpol);
      chk1($sformatf("v%0d_end_busy", i), busy, 1'b0);
      chk1($sformatf("v%0d_end_ss_n", i), ss_n, 1'b1);
      chk1($sformatf("v%0d_end_sclk", i), sclk, vecs[i].exp_cpol);
    end

    // Second start mid-SHIFT is rejected and the transfer finishes untouched
    run(MODE_SPI, 32'd2, 32'h27, 32'h000000A5, 37, 10, -1, 11);
    chk("busy_start_done_cycle", done_cyc, 35);
    chk("busy_start_err_pulses", errs, 1);
    chk1("busy_start_err_at_11", s_err, 1'b1);
    chk("busy_start_rx", rx_data, 32'h000000A5);

    // Illegal starts: clkdiv 0, then reserved mode
    run(MODE_SPI, 32'd0, 32'h27, 32'h0000005A, 6, -1, -1, 1);
    chk("div0_err_pulses", errs, 1);
    chk1("div0_ss_n", s_ss, 1'b1);
    chk1("div0_busy", s_busy, 1'b0);
    chk("div0_no_done", done_cyc, -1);
    run(2'b10, 32'd2, 32'h27, 32'h0000005A, 6, -1, -1, 1);
    chk("mode2_err_pulses", errs, 1);
    chk1("mode2_ss_n", s_ss, 1'b1);
    chk1("mode2_busy", s_busy, 1'b0);
    chk("mode2_no_done", done_cyc, -1);

    // Mode switched off mid-SHIFT
    run(MODE_SPI, 32'd2, 32'h27, 32'h0000003C, 40, -1, 12, 13);
    chk1("abort_ss_n", s_ss, 1'b1);
    chk1("abort_busy", s_busy, 1'b0);
    chk1("abort_sclk", s_sclk, 1'b0);
    chk1("abort_err", s_err, 1'b1);
    chk("abort_err_pulses", errs, 1);
    chk("abort_no_done", done_cyc, -1);
    chk("abort_rx_hold", rx_data, 32'h000000A5);

    // Abort coinciding with tx_start
    run(MODE_SPI, 32'd2, 32'h27, 32'h0000003C, 20, 12, 12, 13);
    chk("abort_start_err_pulses", errs, 1);
    chk1("abort_start_busy", s_busy, 1'b0);
    chk("abort_start_no_done", done_cyc, -1);

    // Reset asserted mid-SHIFT, then a clean transfer
    run(MODE_SPI, 32'd1, 32'h5F, 32'hDEADBEEF, 10, -1, -1, 0);
    nRST = 1'b0;
    #1;
    chk1("midrst_sclk", sclk, 1'b0);
    chk1("midrst_mosi", mosi, 1'b0);
    chk1("midrst_ss_n", ss_n, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_err", ctrl_unit_error, 1'b0);
    chk("midrst_rx", rx_data, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    run(MODE_SPI, 32'd2, 32'h27, 32'h000000A5, 37, -1, -1, 1);
    chk("postrst_done_cycle", done_cyc, 35);
    chk("postrst_rx", rx_data, 32'h000000A5);
    chk("postrst_sclk_pulses", pulses, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usi_spi_engine.md
USI_SPI_ENGINE -- requirements
Module: usi_spi_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the transmit and receive data paths.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port mode_sel  input  2  mode from the register map; 2'b00 off, 2'b01 SPI, 2'b1x reserved.
REQ-005 SHALL have port clkdiv  input  32  SCLK half-period in CLK cycles; 0 is illegal.
REQ-006 SHALL have port parameters  input  32  [4:0] bit count minus 1, [5] msb_first, [6] cpol; other bits ignored.
REQ-007 SHALL have port tx_data  input  DATA_W  transmit word, right-justified.
REQ-008 SHALL have port tx_start  input  1  one-cycle pulse requesting a transfer (issued on a write to tx_data).
REQ-009 SHALL have port miso  input  1  serial input, synchronous to CLK.
REQ-010 SHALL have port sclk, mosi, ss_n  output  1 each  serial clock, serial out, active-low select.
REQ-011 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at transfer completion.
REQ-013 SHALL have port rx_data  output  DATA_W  last received word (drives the register map's buffer_read).
REQ-014 SHALL have port ctrl_unit_error  output  1  one-cycle error pulse (drives the register map's ctrl_unit_error).

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
REQ-016 In IDLE, tx_start with mode_sel==01 and clkdiv!=0 SHALL go to LOAD on the next cycle.
REQ-017 On entering LOAD, SHALL latch clkdiv, N = parameters[4:0]+1 (1..32), msb_first and cpol; later input changes SHALL NOT affect the transfer in flight.
REQ-018 On entering LOAD, SHALL load the shift register from tx_data and drive ss_n=0, busy=1, and mosi = first bit (bit N-1 if msb_first, else bit 0).
REQ-019 LOAD SHALL last clkdiv cycles (setup half-period); SHIFT SHALL last 2*N*clkdiv cycles; DONE SHALL last 1 cycle.
REQ-020 Tick: the half-period counter SHALL count 0..clkdiv-1 and issue a tick at terminal count; each SHIFT tick SHALL toggle sclk.
REQ-021 Edge protocol: on odd ticks (leading edge), SHALL sample miso; on even ticks (trailing edge), SHALL shift and drive the next bit on mosi.
REQ-022 Idle level of sclk SHALL equal the latched cpol; sclk SHALL return to cpol at the end of SHIFT.
REQ-023 rx_data SHALL be right-justified with bits above N-1 zero, SHALL update only in DONE, and SHALL hold until the next DONE.
REQ-024 In DONE, SHALL drive done=1 and ss_n=1; busy SHALL fall on the following cycle. For tx_start at cycle 0, done SHALL occur at cycle 1+clkdiv*(2N+1).
REQ-025 tx_start while busy SHALL be ignored and SHALL pulse ctrl_unit_error for 1 cycle.
REQ-026 tx_start in IDLE with mode_sel!=01 or clkdiv==0 SHALL pulse ctrl_unit_error and SHALL leave the FSM in IDLE.
REQ-027 If mode_sel!=01 during LOAD/SHIFT, SHALL abort: next cycle IDLE, ss_n=1, sclk=cpol, busy=0, no done, rx_data unchanged, ctrl_unit_error pulsed.
REQ-028 If abort and tx_start coincide, abort SHALL take priority and SHALL generate a single error pulse.

Reset
REQ-029 On nRST low, SHALL immediately enter IDLE, including mid-transfer.
REQ-030 Reset values SHALL be: sclk=0, mosi=0, ss_n=1, busy=0, done=0, rx_data=0, ctrl_unit_error=0, latched cpol=0, counters=0.

Structure
REQ-031 Package usi_pkg SHALL hold the FSM state enum, MODE_OFF/MODE_SPI constants, and parameters field positions (NBITS_LSB/MSB, MSB_FIRST_BIT, CPOL_BIT).
REQ-032 Sub-module usi_clk_gen SHALL hold the half-period counter, with inputs enable and div and output tick.
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 Loopback (miso=mosi), mode 01, clkdiv=2, N=8, msb_first=1, tx_data=0xA5, pulse tx_start -> 8 SCLK pulses, MOSI pattern 1,0,1,0,0,1,0,1, done at cycle 35, rx_data=0x000000A5.
REQ-035 Loopback, clkdiv=1, N=32, lsb_first, cpol=1, tx_data=0xDEADBEEF -> sclk idles high, done at cycle 66, rx_data=0xDEADBEEF.
REQ-036 tx_start during SHIFT -> single ctrl_unit_error pulse, transfer completes unaffected.
REQ-037 tx_start with clkdiv=0 or mode_sel=10 -> error pulse, ss_n stays 1, busy stays 0.
REQ-038 mode_sel set to 00 mid-SHIFT -> next cycle ss_n=1, busy=0, error pulse, no done, rx_data holds previous value.
REQ-039 nRST asserted mid-SHIFT -> outputs at reset values; a new tx_start after release yields a correct transfer.
